shift_frame_ctrl: RTL and testbench
===================================

# shift_frame_ctrl

Frame sequencer for the `ShiftReg` universal shift register. It accepts a WIDTH-bit word over a valid/ready handshake, drives `Mode_Control` to parallel-load the word and shift it out in WIDTH cycles (MSB- or LSB-first). It then returns the word that was shifted in serially during the same frame. It sits between the host logic and one `ShiftReg` instance and owns that register's mode input exclusively.

## Interface
- `WIDTH`, 8, frame length in bits; must equal the `ShiftReg` width; legal range ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `tx_valid`  in  1  host offers a word.
- `tx_ready`  out  1  controller can accept a word.
- `tx_data`  in  WIDTH  word to transmit.
- `msb_first`  in  1  sampled with `tx_data`: 1 = shift left, 0 = shift right.
- `sr_mode`  out  2  to `ShiftReg.Mode_Control`.
- `sr_p_data`  out  WIDTH  to `ShiftReg.P_DataIn`.
- `sr_p_q`  in  WIDTH  from `ShiftReg.P_DataOut`.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle end-of-frame pulse.
- `rx_data`  out  WIDTH  word captured from `sr_p_q` at end of frame.
- `pause`  in  1  present only with `SHIFT_FRAME_PAUSE_EN`.

## Operation
- Mode encoding:
  - 00 = HOLD
  - 01 = shift left
  - 10 = shift right
  - 11 = parallel LOAD
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `tx_ready` = 1, `sr_mode` = 00.
  - On `tx_valid & tx_ready`, register `tx_data` into `sr_p_data`, register `msb_first`, and go to LOAD.
- LOAD:
  - `sr_mode` = 11 for exactly one cycle, then go to SHIFT with `bit_cnt` = 0.
- SHIFT:
  - `sr_mode` = 01 if the registered `msb_first` = 1, else 10.
  - `bit_cnt` increments each cycle.
  - When `bit_cnt` = WIDTH-1, go to DONE.
- DONE:
  - `sr_mode` = 00.
  - At the end of this cycle, `rx_data` <= `sr_p_q`, `done` <= 1, and go to IDLE.
- `sr_mode` is a combinational decode of the registered state (and `pause`). All other outputs are registered.
- `busy` = 1 in LOAD, SHIFT and DONE.
- `tx_ready` = 1 only in IDLE. `tx_valid` while busy is ignored, and `tx_data` is not re-sampled.
- `bit_cnt` width is $clog2(WIDTH). It never wraps past WIDTH-1.
- `rx_data` holds its value until the next DONE.

## Timing
- Reset values: state IDLE, `sr_mode` 00, `sr_p_data` 0, `rx_data` 0, `done` 0, `busy` 0, `tx_ready` 1 in the first cycle after reset, `bit_cnt` 0.
- Frame timeline, handshake in cycle T0:
  - T1: LOAD.
  - T2..T(WIDTH+1): SHIFT.
  - T(WIDTH+2): DONE.
  - T(WIDTH+3): IDLE with `done` = 1 and `tx_ready` = 1.
- For WIDTH = 8, `done` is seen in T11.
- Back-to-back frames: a handshake in the `done` cycle is legal, so throughput is one frame per WIDTH+3 cycles.
- Reset asserted mid-frame: the next edge forces IDLE and reset values, and the frame is discarded. No `done` is produced.

## Configuration
- `SHIFT_FRAME_PAUSE_EN` defined:
  - `pause` port exists.
  - `pause` = 1 in a SHIFT cycle forces `sr_mode` = 00 in that same cycle and freezes `bit_cnt` and state.
  - `pause` is ignored in IDLE, LOAD and DONE.
- `SHIFT_FRAME_PAUSE_EN` undefined: no `pause` port, and SHIFT runs uninterrupted for exactly WIDTH cycles.

## Structure
- Package `shift_frame_pkg` holds:
  - mode constants `MODE_HOLD`, `MODE_SHL`, `MODE_SHR`, `MODE_LOAD`;
  - the state enum `shift_frame_state_t`.
- One sub-module, `shift_bit_cnt`: a loadable up-counter with enable and terminal-count flag at WIDTH-1.
- Bench instantiates `shift_frame_ctrl` with a real `ShiftReg` (WIDTH = 8) and drives `ShiftReg.S_DataIn` from a bit stream.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles -> `sr_mode` = 00, `busy` = 0, `done` = 0, `rx_data` = 0, and `tx_ready` = 1 after release.
- MSB-first frame: `tx_data` = 8'hCC, `msb_first` = 1, S_DataIn stream 1,0,1,0,0,1,0,1 -> `sr_mode` sequence is 11 then 01 ×8 then 00; `S_DataOut` emits 1,1,0,0,1,1,0,0; `done` in T11; `rx_data` = 8'hA5.
- LSB-first frame: `tx_data` = 8'h81, `msb_first` = 0 -> `sr_mode` = 10 for 8 cycles; `done` in T11.
- Handshake: assert `tx_valid` with 8'h3C during a busy frame -> not accepted and no second load; `tx_ready` = 0 until the `done` cycle. Back-to-back handshake at `done` -> LOAD in the next cycle.
- Reset mid-SHIFT (cycle T5): -> IDLE next edge, `sr_mode` = 00, no `done` pulse, `rx_data` unchanged from reset value.
- With `SHIFT_FRAME_PAUSE_EN`: `pause` high for 3 cycles during SHIFT -> `sr_mode` = 00 for those cycles; `done` moves from T11 to T14; `rx_data` unchanged versus the unpaused run.

Source files
------------

// File: rtl/shift_frame_pkg.sv
// Shared mode encodings and FSM state type for the shift frame sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package shift_frame_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } shift_frame_state_t;

endpackage

// File: rtl/ShiftReg.sv
// Universal shift register: hold, shift left, shift right, parallel load.
// Latency: one cycle from Mode_Control/inputs to P_DataOut.
// Backpressure: none; the mode input alone decides what happens each cycle.
module ShiftReg
    import shift_frame_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       Mode_Control,
    input  logic [WIDTH-1:0] P_DataIn,
    input  logic             S_DataIn,
    output logic [WIDTH-1:0] P_DataOut,
    output logic             S_DataOut
);

    logic [WIDTH-1:0] q;

    // Register update selected by the two-bit mode control.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            case (Mode_Control)
                MODE_SHL:  q <= {q[WIDTH-2:0], S_DataIn};
                MODE_SHR:  q <= {S_DataIn, q[WIDTH-1:1]};
                MODE_LOAD: q <= P_DataIn;
                default:   q <= q;
            endcase
        end
    end

    assign P_DataOut = q;
    // The serial output is whichever end bit leaves on the next shift.
    assign S_DataOut = (Mode_Control == MODE_SHR) ? q[0] : q[WIDTH-1];

endmodule

// File: rtl/shift_bit_cnt.sv
// Loadable up-counter with enable; flags terminal count at WIDTH-1.
// Latency: count updates one cycle after load/en; termCnt is combinational.
// Backpressure: en low holds the count; the counter saturates at WIDTH-1.
module shift_bit_cnt #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [$clog2(WIDTH)-1:0] loadVal,
    input  logic                     en,
    output logic                     termCnt
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count;

    // Load has priority over counting; never advance beyond the terminal value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (en && !termCnt) begin
            count <= count + 1'b1;
        end
    end

    assign termCnt = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_frame_ctrl.sv
// Frame sequencer: loads a word into ShiftReg, shifts it WIDTH cycles, returns the shifted-in word.
// Latency: handshake at T0, done pulse and rx_data at T(WIDTH+3) (plus any pause cycles).
// Backpressure: tx_ready only in IDLE; optional pause (SHIFT_FRAME_PAUSE_EN) stalls the SHIFT phase.
module shift_frame_ctrl
    import shift_frame_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             msb_first,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_p_data,
    input  logic [WIDTH-1:0] sr_p_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
`ifdef SHIFT_FRAME_PAUSE_EN
    ,
    input  logic             pause
`endif
);

    localparam int CW = $clog2(WIDTH);

    shift_frame_state_t state;
    shift_frame_state_t nextState;

    logic msbFirstReg;
    logic holdShift;
    logic accept;
    logic cntTc;

`ifdef SHIFT_FRAME_PAUSE_EN
    assign holdShift = pause;
`else
    assign holdShift = 1'b0;
`endif

    assign accept = tx_valid && tx_ready;

    shift_bit_cnt #(
        .WIDTH   (WIDTH)
    ) u_bit_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == ST_LOAD),
        .loadVal ({CW{1'b0}}),
        .en      ((state == ST_SHIFT) && !holdShift),
        .termCnt (cntTc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and mode decode; pause only affects SHIFT.
    always_comb begin
        nextState = state;
        sr_mode   = MODE_HOLD;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nextState = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sr_mode   = MODE_LOAD;
                nextState = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!holdShift) begin
                    sr_mode = msbFirstReg ? MODE_SHL : MODE_SHR;
                    if (cntTc) begin
                        nextState = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    // Registered outputs: capture request on handshake, result on DONE, status from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_p_data   <= '0;
            msbFirstReg <= 1'b0;
            rx_data     <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
        end else begin
            if (accept) begin
                sr_p_data   <= tx_data;
                msbFirstReg <= msb_first;
            end
            if (state == ST_DONE) begin
                rx_data <= sr_p_q;
            end
            done     <= (state == ST_DONE);
            busy     <= (nextState != ST_IDLE);
            tx_ready <= (nextState == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Bench for shift_frame_ctrl driving a real ShiftReg; randomized frames against a frame-level model.
// Latency: checks done/rx_data WIDTH+3 cycles after each handshake (plus pause cycles).
// Backpressure: exercises ignored tx_valid while busy and back-to-back handshakes at done.
module tb_shift_frame_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tx_valid = 1'b0;
    logic         msb_first = 1'b0;
    logic         sIn = 1'b0;
    logic [W-1:0] tx_data = '0;
`ifdef SHIFT_FRAME_PAUSE_EN
    logic         pause = 1'b0;
`endif

    logic         tx_ready;
    logic [1:0]   sr_mode;
    logic [W-1:0] sr_p_data;
    logic [W-1:0] sr_p_q;
    logic         busy;
    logic         done;
    logic [W-1:0] rx_data;
    logic         sOut;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] lastRx = '0;

    always #5 clk = ~clk;

    shift_frame_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .msb_first (msb_first),
        .sr_mode   (sr_mode),
        .sr_p_data (sr_p_data),
        .sr_p_q    (sr_p_q),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data)
`ifdef SHIFT_FRAME_PAUSE_EN
        ,
        .pause     (pause)
`endif
    );

    ShiftReg #(.WIDTH(W)) u_sr (
        .clk          (clk),
        .rst_n        (rst_n),
        .Mode_Control (sr_mode),
        .P_DataIn     (sr_p_data),
        .S_DataIn     (sIn),
        .P_DataOut    (sr_p_q),
        .S_DataOut    (sOut)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles: nothing moves, rx_data holds its last captured value.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            checkVal("idle_mode", {30'd0, sr_mode}, 32'd0);
            checkVal("idle_busy", {31'd0, busy}, 32'd0);
            checkVal("idle_done", {31'd0, done}, 32'd0);
            checkVal("idle_ready", {31'd0, tx_ready}, 32'd1);
            checkVal("idle_rx", {24'd0, rx_data}, {24'd0, lastRx});
        end
    endtask

    // One frame: caller is in an IDLE cycle (T0); returns in the done cycle.
    // Shift bit k is stream[W-1-k], so the stream reads left to right in time.
    task automatic runFrame(input logic [W-1:0] data, input logic msb, input logic [W-1:0] stream,
                            input int pStart, input int pLen, input logic busyValid);
        logic [W-1:0] expRx;
        logic [1:0]   shiftMode;
        logic         paused;
        int           k;
        int           t;
        expRx = '0;
        for (int i = 0; i < W; i++) begin
            if (msb) expRx[W-1-i] = stream[W-1-i];
            else     expRx[i]     = stream[W-1-i];
        end
        shiftMode = msb ? 2'b01 : 2'b10;

        tx_valid  = 1'b1;
        tx_data   = data;
        msb_first = msb;
        checkVal("t0_ready", {31'd0, tx_ready}, 32'd1);

        nextCycle();
        t = 1;
        tx_valid  = busyValid;
        tx_data   = busyValid ? 8'h3C : W'($urandom);
        msb_first = ~msb;
        checkVal("load_mode", {30'd0, sr_mode}, 32'd3);
        checkVal("load_busy", {31'd0, busy}, 32'd1);
        checkVal("load_ready", {31'd0, tx_ready}, 32'd0);
        checkVal("load_done", {31'd0, done}, 32'd0);

        k = 0;
        while (k < W) begin
            nextCycle();
            t++;
            paused = (t >= pStart) && (t < pStart + pLen);
`ifdef SHIFT_FRAME_PAUSE_EN
            pause = paused;
`endif
            sIn = stream[W-1-k];
            checkVal("shift_busy", {31'd0, busy}, 32'd1);
            checkVal("shift_ready", {31'd0, tx_ready}, 32'd0);
            checkVal("shift_done", {31'd0, done}, 32'd0);
            if (paused) begin
                checkVal("pause_mode", {30'd0, sr_mode}, 32'd0);
            end else begin
                checkVal("shift_mode", {30'd0, sr_mode}, {30'd0, shiftMode});
                checkVal("shift_sout", {31'd0, sOut}, {31'd0, msb ? data[W-1-k] : data[k]});
                k++;
            end
        end

        nextCycle();
`ifdef SHIFT_FRAME_PAUSE_EN
        pause = 1'b0;
`endif
        tx_valid = 1'b0;
        checkVal("dstate_mode", {30'd0, sr_mode}, 32'd0);
        checkVal("dstate_busy", {31'd0, busy}, 32'd1);
        checkVal("dstate_ready", {31'd0, tx_ready}, 32'd0);
        checkVal("dstate_done", {31'd0, done}, 32'd0);

        nextCycle();
        checkVal("done_pulse", {31'd0, done}, 32'd1);
        checkVal("done_rx", {24'd0, rx_data}, {24'd0, expRx});
        checkVal("done_busy", {31'd0, busy}, 32'd0);
        checkVal("done_ready", {31'd0, tx_ready}, 32'd1);
        checkVal("done_mode", {30'd0, sr_mode}, 32'd0);
        lastRx = expRx;
    endtask

    // Reset asserted in T5 (mid-SHIFT): frame is dropped, no done, rx_data cleared.
    task automatic resetMidShift();
        tx_valid  = 1'b1;
        tx_data   = W'($urandom);
        msb_first = 1'($urandom_range(0, 1));
        nextCycle();
        tx_valid = 1'b0;
        repeat (4) nextCycle();
        rst_n = 1'b0;
        nextCycle();
        checkVal("rst_mid_mode", {30'd0, sr_mode}, 32'd0);
        checkVal("rst_mid_busy", {31'd0, busy}, 32'd0);
        checkVal("rst_mid_done", {31'd0, done}, 32'd0);
        checkVal("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
        checkVal("rst_mid_rx", {24'd0, rx_data}, 32'd0);
        rst_n  = 1'b1;
        lastRx = '0;
        idleCycles(14);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) nextCycle();
        checkVal("rst_mode", {30'd0, sr_mode}, 32'd0);
        checkVal("rst_busy", {31'd0, busy}, 32'd0);
        checkVal("rst_done", {31'd0, done}, 32'd0);
        checkVal("rst_rx", {24'd0, rx_data}, 32'd0);
        rst_n = 1'b1;
        nextCycle();
        checkVal("rst_ready", {31'd0, tx_ready}, 32'd1);
        idleCycles(2);

        // Directed MSB-first frame: emits CC, captures A5.
        runFrame(8'hCC, 1'b1, 8'hA5, 0, 0, 1'b0);
        idleCycles(2);
        // Directed LSB-first frame.
        runFrame(8'h81, 1'b0, W'($urandom), 0, 0, 1'b0);
        idleCycles(1);
        // tx_valid held with 3C during the frame, then back-to-back at done.
        runFrame(8'h5A, 1'b1, W'($urandom), 0, 0, 1'b1);
        runFrame(8'h96, 1'b0, W'($urandom), 0, 0, 1'b0);
        idleCycles(1);

        resetMidShift();

        for (int i = 0; i < 25; i++) begin
            runFrame(W'($urandom), 1'($urandom_range(0, 1)), W'($urandom), 0, 0,
                     1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 3));
        end

`ifdef SHIFT_FRAME_PAUSE_EN
        idleCycles(1);
        // Pause T4..T6: three held SHIFT cycles, same captured word as unpaused run.
        runFrame(8'hCC, 1'b1, 8'hA5, 4, 3, 1'b0);
        idleCycles(1);
        for (int i = 0; i < 6; i++) begin
            runFrame(W'($urandom), 1'($urandom_range(0, 1)), W'($urandom),
                     $urandom_range(2, 8), $urandom_range(1, 4), 1'b0);
        end
`endif
        idleCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
